// File: rtl/leitor_botoes.sv
// rtl/leitor_botoes.sv - debounced push-button reader producing one-cycle press pulses
//
// Purpose:
//   Samples the raw, bouncing puzzle buttons and turns each physical press into
//   exactly one registered pulse on botoes. It also keeps a saturating count of
//   the pulses it has emitted.
//
// Ports:
//   clk          main clock
//   rst          asynchronous active-low reset
//   botoes_raw   raw button pins, asynchronous to clk
//   habilitar    1 = presses generate pulses, 0 = events are discarded
//   botoes       one-cycle press pulses
//   pressionados debounced level per button, 1 = held
//   movimentos   number of pulses emitted, saturating at 255
//   pendente     a press is queued but not yet emitted
//
// Build option:
//   SERIAL_PULSOS_EN - serialise pulses so at most one botoes bit is high per
//                      cycle, lowest index first. When undefined, every
//                      qualifying bit pulses at once and pendente is 0.
module leitor_botoes #(
    parameter int N_BOTOES        = 6,
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter bit ATIVO_BAIXO     = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BOTOES-1:0] botoes_raw,
    input  logic                habilitar,
    output logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] pressionados,
    output logic [7:0]          movimentos,
    output logic                pendente
);

    localparam int            CW      = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0] CNT_UM  = CW'(1);

    typedef enum logic [1:0] {
        SOLTO        = 2'd0,
        CONF_PRESSAO = 2'd1,
        PRESSIONADO  = 2'd2,
        CONF_SOLTURA = 2'd3
    } estado_t;

    logic [N_BOTOES-1:0] raw_norm;
    logic [N_BOTOES-1:0] sync1;
    logic [N_BOTOES-1:0] s;
    logic [N_BOTOES-1:0] evento;

    // After normalisation 1 always means "pressed", so clearing the
    // synchronizers to 0 makes a button held through reset look like a new press.
    assign raw_norm = ATIVO_BAIXO ? ~botoes_raw : botoes_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= raw_norm;
            s     <= sync1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < N_BOTOES; i++) begin : g_btn
            estado_t       estado, prox_estado;
            logic [CW-1:0] cnt, prox_cnt;
            logic          nivel, ev;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    estado <= SOLTO;
                    cnt    <= '0;
                end else begin
                    estado <= prox_estado;
                    cnt    <= prox_cnt;
                end
            end

            always_comb begin
                prox_estado = estado;
                prox_cnt    = cnt;
                case (estado)
                    SOLTO: begin
                        if (s[i]) begin
                            prox_estado = CONF_PRESSAO;
                            prox_cnt    = CNT_UM;
                        end
                    end
                    CONF_PRESSAO: begin
                        if (!s[i]) begin
                            prox_estado = SOLTO;
                            prox_cnt    = '0;
                        end else if (cnt == CNT_MAX) begin
                            prox_estado = PRESSIONADO;
                            prox_cnt    = '0;
                        end else begin
                            prox_cnt = cnt + CNT_UM;
                        end
                    end
                    PRESSIONADO: begin
                        if (!s[i]) begin
                            prox_estado = CONF_SOLTURA;
                            prox_cnt    = CNT_UM;
                        end
                    end
                    CONF_SOLTURA: begin
                        if (s[i]) begin
                            prox_estado = PRESSIONADO;
                            prox_cnt    = '0;
                        end else if (cnt == CNT_MAX) begin
                            prox_estado = SOLTO;
                            prox_cnt    = '0;
                        end else begin
                            prox_cnt = cnt + CNT_UM;
                        end
                    end
                    default: begin
                        prox_estado = SOLTO;
                        prox_cnt    = '0;
                    end
                endcase
            end

            always_comb begin
                nivel = (estado == PRESSIONADO) || (estado == CONF_SOLTURA);
                ev    = (estado == CONF_PRESSAO) && s[i] && (cnt == CNT_MAX);
            end

            assign pressionados[i] = nivel;
            assign evento[i]       = ev;
        end
    endgenerate

`ifdef SERIAL_PULSOS_EN
    logic [N_BOTOES-1:0] pend;
    logic [N_BOTOES-1:0] combinado;
    logic [N_BOTOES-1:0] concessao;

    // A fresh event joins the pending set in the same cycle, so the lowest
    // requester is emitted with no extra delay; x & -x isolates the lowest set bit.
    assign combinado = pend | evento;
    assign concessao = combinado & (-combinado);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend   <= '0;
            botoes <= '0;
        end else if (!habilitar) begin
            pend   <= '0;
            botoes <= '0;
        end else begin
            pend   <= combinado & ~concessao;
            botoes <= concessao;
        end
    end

    assign pendente = |pend;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            botoes <= '0;
        end else begin
            botoes <= habilitar ? evento : '0;
        end
    end

    assign pendente = 1'b0;
`endif

    logic [8:0] qtd;
    logic [8:0] soma;

    always_comb begin
        qtd = '0;
        for (int k = 0; k < N_BOTOES; k++) begin
            qtd = qtd + 9'(botoes[k]);
        end
        soma = {1'b0, movimentos} + qtd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            movimentos <= '0;
        end else if (soma > 9'd255) begin
            movimentos <= 8'd255;
        end else begin
            movimentos <= soma[7:0];
        end
    end

endmodule

// File: tb/tb_leitor_botoes.sv
// tb/tb_leitor_botoes.sv - directed self-checking bench for leitor_botoes
module tb_leitor_botoes;

    logic       clk;
    logic       rst;
    logic [5:0] botoes_raw;
    logic       habilitar;
    logic [5:0] botoes;
    logic [5:0] pressionados;
    logic [7:0] movimentos;
    logic       pendente;

    int n_cmp;
    int n_err;
    int n_pulsos;
    logic [5:0] visto_botoes;
    logic [5:0] visto_press;

    leitor_botoes #(
        .N_BOTOES       (6),
        .DEBOUNCE_CICLOS(4),
        .ATIVO_BAIXO    (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .botoes_raw  (botoes_raw),
        .habilitar   (habilitar),
        .botoes      (botoes),
        .pressionados(pressionados),
        .movimentos  (movimentos),
        .pendente    (pendente)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        botoes_raw = 6'b111111;
        habilitar  = 1'b1;
        #3;
        chk("reset_botoes", 32'(botoes), 32'h0);
        chk("reset_pressionados", 32'(pressionados), 32'h0);
        chk("reset_movimentos", 32'(movimentos), 32'h0);
        chk("reset_pendente", 32'(pendente), 32'h0);
        step(2);
        rst = 1'b1;
        step(3);

        // Clean press on button 2: pulse 7 cycles after the raw edge.
        botoes_raw[2] = 1'b0;
        step(6);
        chk("clean_before_latency", 32'(botoes), 32'h0);
        step(1);
        chk("clean_pulse", 32'(botoes), 32'h04);
        chk("clean_pressionados", 32'(pressionados), 32'h04);
        chk("clean_pendente", 32'(pendente), 32'h0);
        step(1);
        chk("clean_pulse_one_cycle", 32'(botoes), 32'h0);
        chk("clean_movimentos", 32'(movimentos), 32'h1);
        step(12);
        botoes_raw[2] = 1'b1;
        visto_botoes = '0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            visto_botoes = visto_botoes | botoes;
        end
        chk("release_no_pulse", 32'(visto_botoes), 32'h0);
        chk("release_pressionados", 32'(pressionados), 32'h0);
        chk("release_movimentos", 32'(movimentos), 32'h1);

        // Bounce on button 0: never stable for 4 synchronized cycles.
        visto_botoes = '0;
        visto_press  = '0;
        for (int c = 0; c < 15; c++) begin
            botoes_raw[0] = ~botoes_raw[0];
            step(1);
            visto_botoes = visto_botoes | botoes;
            visto_press  = visto_press | pressionados;
            step(1);
            visto_botoes = visto_botoes | botoes;
            visto_press  = visto_press | pressionados;
        end
        botoes_raw[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(1);
            visto_botoes = visto_botoes | botoes;
            visto_press  = visto_press | pressionados;
        end
        chk("bounce_no_pulse", 32'(visto_botoes), 32'h0);
        chk("bounce_no_level", 32'(visto_press), 32'h0);
        chk("bounce_movimentos", 32'(movimentos), 32'h1);

        // Simultaneous press of buttons 1 and 4.
        botoes_raw[1] = 1'b0;
        botoes_raw[4] = 1'b0;
        step(7);
`ifdef SERIAL_PULSOS_EN
        chk("serial_first", 32'(botoes), 32'h02);
        chk("serial_first_pendente", 32'(pendente), 32'h1);
        step(1);
        chk("serial_second", 32'(botoes), 32'h10);
        chk("serial_second_pendente", 32'(pendente), 32'h0);
        step(1);
        chk("serial_done", 32'(botoes), 32'h0);
        chk("serial_movimentos", 32'(movimentos), 32'h3);
`else
        chk("simul_pulse", 32'(botoes), 32'h12);
        step(1);
        chk("simul_pulse_one_cycle", 32'(botoes), 32'h0);
        chk("simul_movimentos", 32'(movimentos), 32'h3);
`endif
        botoes_raw[1] = 1'b1;
        botoes_raw[4] = 1'b1;
        step(12);

        // habilitar low during the event cycle of a press on button 3.
        botoes_raw[3] = 1'b0;
        step(6);
        habilitar = 1'b0;
        step(1);
        chk("disabled_no_pulse", 32'(botoes), 32'h0);
        chk("disabled_pressionados", 32'(pressionados), 32'h08);
        habilitar = 1'b1;
        step(3);
        chk("disabled_not_deferred", 32'(botoes), 32'h0);
        chk("disabled_movimentos", 32'(movimentos), 32'h3);
        botoes_raw[3] = 1'b1;
        step(12);
        botoes_raw[3] = 1'b0;
        n_pulsos = 0;
        for (int c = 0; c < 14; c++) begin
            step(1);
            if (botoes[3]) n_pulsos++;
        end
        chk("repress_one_pulse", 32'(n_pulsos), 32'd1);
        chk("repress_movimentos", 32'(movimentos), 32'h4);
        botoes_raw[3] = 1'b1;
        step(12);

        // 260 more presses on button 5: the counter must stop at 255.
        for (int p = 0; p < 260; p++) begin
            botoes_raw[5] = 1'b0;
            step(8);
            botoes_raw[5] = 1'b1;
            step(8);
        end
        chk("saturated_movimentos", 32'(movimentos), 32'd255);

        // Asynchronous reset while button 5 is held.
        botoes_raw[5] = 1'b0;
        step(9);
        chk("held_before_reset", 32'(pressionados), 32'h20);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_pressionados", 32'(pressionados), 32'h0);
        chk("async_reset_movimentos", 32'(movimentos), 32'h0);
        chk("async_reset_botoes", 32'(botoes), 32'h0);
        chk("async_reset_pendente", 32'(pendente), 32'h0);
        step(2);
        rst = 1'b1;
        step(6);
        chk("post_reset_before_latency", 32'(botoes), 32'h0);
        step(1);
        chk("post_reset_pulse", 32'(botoes), 32'h20);
        step(1);
        chk("post_reset_movimentos", 32'(movimentos), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/leitor_botoes.md
Name: leitor_botoes

Overview:
- Input side of the LED-matrix puzzle. Samples the raw, bouncing push-buttons and produces clean one-cycle toggle pulses on `botoes`, which feed `matriz_leds.botoes`.
- Each physical press yields exactly one pulse. Releases and contact bounce produce none.
- Also keeps a saturating move counter that the control unit uses for scoring.

Parameters:
- N_BOTOES, 6: number of buttons; width of the button buses.
- DEBOUNCE_CICLOS, 50000: consecutive stable cycles required to accept a level change; must be >= 1.
- ATIVO_BAIXO, 1: 1 means a raw low is "pressed"; 0 means a raw high is "pressed".

Ports:
- clk  input  1  FPGA main clock.
- rst  input  1  reset, asynchronous, active-low.
- botoes_raw  input  N_BOTOES  raw button pins, asynchronous to clk.
- habilitar  input  1  1 = presses generate pulses; 0 = presses ignored (level locked).
- botoes  output  N_BOTOES  one-cycle press pulses to the matrix controller.
- pressionados  output  N_BOTOES  debounced level per button, 1 = held.
- movimentos  output  8  count of pulses emitted; saturates at 255.
- pendente  output  1  1 while any press is queued but not yet emitted (always 0 without the optional feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0.
  - Synchronizers are cleared to the "released" level.
  - All counters go to 0 and every per-button FSM goes to SOLTO.
- Input path:
  - Each raw bit is polarity-normalised by ATIVO_BAIXO, then passes through a 2-flop synchronizer.
  - The FSM sees only the synchronized value `s`.
- Per-button FSM, with counter `cnt` of width $clog2(DEBOUNCE_CICLOS+1):
  - SOLTO: if s=1, set cnt=1 and go to CONF_PRESSAO.
  - CONF_PRESSAO:
    - If s=0, return to SOLTO and set cnt=0.
    - Else if cnt==DEBOUNCE_CICLOS, go to PRESSIONADO and raise a press event.
    - Else cnt++.
  - PRESSIONADO: if s=0, set cnt=1 and go to CONF_SOLTURA.
  - CONF_SOLTURA:
    - If s=1, return to PRESSIONADO and set cnt=0.
    - Else if cnt==DEBOUNCE_CICLOS, go to SOLTO (no event).
    - Else cnt++.
- `pressionados[i]` is 1 in states PRESSIONADO and CONF_SOLTURA.
- Pulse output:
  - `botoes` is registered.
  - A press event drives botoes[i]=1 for exactly one cycle, and only if habilitar=1 in the event cycle.
  - Latency from the first raw sample in the pressed level to the pulse is 2 + DEBOUNCE_CICLOS + 1 cycles.
- A glitch shorter than DEBOUNCE_CICLOS synchronized cycles produces no pulse and no change to `pressionados`.
- While held, no further pulses are produced; a new pulse requires a full debounced release first.
- movimentos:
  - Increments by the number of bits set in `botoes` in that cycle.
  - Saturates at 255 and never wraps.
  - Cleared only by reset.
- habilitar=0: FSMs keep tracking levels, but events are discarded; they are not deferred.
- A button held through reset release is treated as a new press: one pulse after the normal latency.
- Simultaneous events: all qualifying bits pulse in the same cycle (default build).

Optional Feature:
- Macro: SERIAL_PULSOS_EN.
- Defined:
  - Events are latched into a pending register.
  - At most one `botoes` bit pulses per cycle, lowest index first.
  - Each bit is cleared when emitted; `pendente` = OR of the pending register.
  - This keeps overlapping LED groups from being toggled in the same cycle.
  - A new event on an already-pending bit is merged into it, so at most one pulse is owed per bit.
  - habilitar=0 clears all pending bits immediately.
  - Added latency for bit i is the number of lower-index bits pending ahead of it.
- Undefined: pending logic is absent and `pendente` is tied to 0.

Test Plan (DEBOUNCE_CICLOS=4, ATIVO_BAIXO=1):
- Clean press: drive botoes_raw[2] low and hold 20 cycles.
  - Expect botoes=6'b000100 for one cycle, exactly 7 cycles after the raw edge.
  - Expect pressionados[2]=1 and movimentos=1.
  - Expect no pulse on the subsequent release.
- Bounce: toggle botoes_raw[0] low/high every 2 cycles for 30 cycles, then hold high.
  - Expect no pulse and movimentos=0.
- Simultaneous press, default build: press buttons 1 and 4 in the same cycle.
  - Expect botoes=6'b010010 in a single cycle and movimentos=2.
- Simultaneous press, SERIAL_PULSOS_EN: same stimulus.
  - Expect 6'b000010, then 6'b010000 on the next cycle.
  - Expect pendente=1 only during the first of those cycles.
- habilitar=0 during the event cycle of a press:
  - Expect no pulse, pressionados=1, movimentos unchanged.
  - Then release, re-press with habilitar=1: exactly one pulse.
- Saturation and reset:
  - Produce 260 distinct presses: expect movimentos=255.
  - Assert rst=0 mid-press: all outputs go to 0 immediately (asynchronously).
  - Release rst with the button still held: expect one pulse 7 cycles later.
